// File: rtl/mult_pkg.sv
// Shared definitions for the 8x8 multiplier family: operand/product widths,
// accumulator FSM states and the packet-count width helper.
package mult_pkg;

    localparam int PROD_W = 16;
    localparam int OP_W   = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } accum_state_t;

    // Width needed to hold a count from 0 to max_terms inclusive.
    function automatic int count_width(input int max_terms);
        return $clog2(max_terms + 1);
    endfunction

endpackage

// File: rtl/mult_accum_adder.sv
// Combinational accumulator adder with exported carry out.
// Build option MULT_ACCUM_SATURATE_EN clamps the sum to all-ones on carry.
module mult_accum_adder
    import mult_pkg::*;
#(
    parameter int ACC_W  = 24,
    parameter int PROD_W = 16
) (
    input  logic [ACC_W-1:0]  acc_i,
    input  logic [PROD_W-1:0] prod_i,
    output logic [ACC_W-1:0]  sum_o,
    output logic              carry_o
);

    logic [ACC_W:0] full_sum;

    always_comb begin
        full_sum = {1'b0, acc_i} + (ACC_W+1)'(prod_i);
        carry_o  = full_sum[ACC_W];
`ifdef MULT_ACCUM_SATURATE_EN
        // Once clamped, any further non-zero product carries again, so the clamp is sticky.
        sum_o    = full_sum[ACC_W] ? {ACC_W{1'b1}} : full_sum[ACC_W-1:0];
`else
        sum_o    = full_sum[ACC_W-1:0];
`endif
    end

endmodule

// File: rtl/mult_accum_stage.sv
// Packet accumulator behind the 8x8 multiplier: sums products, presents one result per packet.
// Optional build macro MULT_ACCUM_SATURATE_EN selects saturating instead of wrapping accumulation.
module mult_accum_stage #(
    parameter int PROD_W    = 16,
    parameter int ACC_W     = 24,
    parameter int MAX_TERMS = 256
) (
    input  logic                                         clk,
    input  logic                                         rst_n,
    input  logic                                         in_valid,
    output logic                                         in_ready,
    input  logic [PROD_W-1:0]                            in_product,
    input  logic                                         in_last,
    output logic                                         out_valid,
    input  logic                                         out_ready,
    output logic [ACC_W-1:0]                             out_sum,
    output logic [mult_pkg::count_width(MAX_TERMS)-1:0]  out_count,
    output logic                                         out_ovf
);

    import mult_pkg::*;

    localparam int CNT_W = count_width(MAX_TERMS);

    accum_state_t      state_q, state_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
    logic              ovf_q, ovf_d;
    logic [ACC_W-1:0]  add_sum;
    logic              add_carry;
    logic              accept;
    logic              close;
    logic [PROD_W-1:0] prod_gated;

    assign accept     = in_valid && in_ready;
    // Gate the product so an undriven bus while idle never reaches the adder.
    assign prod_gated = accept ? in_product : '0;
    assign cnt_inc    = cnt_q + CNT_W'(1);
    assign close      = in_last || (cnt_inc == CNT_W'(MAX_TERMS));

    mult_accum_adder #(
        .ACC_W  (ACC_W),
        .PROD_W (PROD_W)
    ) u_adder (
        .acc_i   (acc_q),
        .prod_i  (prod_gated),
        .sum_o   (add_sum),
        .carry_o (add_carry)
    );

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE, ACCUM: begin
                if (accept) begin
                    acc_d   = add_sum;
                    cnt_d   = cnt_inc;
                    ovf_d   = ovf_q | add_carry;
                    state_d = close ? DONE : ACCUM;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                    acc_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    // Result is held in the state registers while DONE, so it stays stable under back-pressure.
    assign in_ready  = (state_q != DONE);
    assign out_valid = (state_q == DONE);
    assign out_sum   = acc_q;
    assign out_count = cnt_q;
    assign out_ovf   = ovf_q;

endmodule
